// File: rtl/narrow_store_pkg.sv
// Shared types and clamp limits for the narrow_store byte serializer.
package narrow_store_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B0   = 2'd1,
    S_B1   = 2'd2
  } state_t;

  localparam logic [7:0] SAT_S_MAX = 8'h7F;
  localparam logic [7:0] SAT_S_MIN = 8'h80;
  localparam logic [7:0] SAT_U_MAX = 8'hFF;

endpackage

// File: rtl/narrow_store_sat.sv
// narrow_sat: combinational clamp of a 16-bit value to one byte, signed or unsigned.
module narrow_sat
  import narrow_store_pkg::*;
(
  input  logic [15:0] val,
  input  logic        acc_s,
  output logic [7:0]  byte_val,
  output logic        sat
);

  // Returns {sat, byte}.
  function automatic logic [8:0] clamp(input logic signed [15:0] v, input logic s);
    logic [8:0] r;
    if (s) begin
      if (v > 16'sd127)
        r = {1'b1, SAT_S_MAX};
      else if (v < -16'sd128)
        r = {1'b1, SAT_S_MIN};
      else
        r = {1'b0, v[7:0]};
    end else begin
      if ($unsigned(v) > 16'd255)
        r = {1'b1, SAT_U_MAX};
      else
        r = {1'b0, v[7:0]};
    end
    return r;
  endfunction

  logic signed [15:0] val_s;

  always_comb begin
    val_s           = $signed(val);
    {sat, byte_val} = clamp(val_s, acc_s);
  end

endmodule

// File: rtl/narrow_store.sv
// narrow_store: serializes a 16-bit store into one (narrow) or two (word) byte beats.
// Define NARROW_STORE_SAT_EN to clamp narrow stores; otherwise they truncate and sat stays 0.
module narrow_store
  import narrow_store_pkg::*;
#(
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] val,
  input  logic        acc_s,
  input  logic        acc_op,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        byte_last,
  output logic        sat
);

  state_t     state;
  logic       op_q;
  logic [7:0] second_q;
  logic [7:0] narrow_byte;
  logic       narrow_sat_flag;
  logic [7:0] first_word_byte;
  logic [7:0] second_word_byte;

`ifdef NARROW_STORE_SAT_EN
  narrow_sat u_sat (
    .val      (val),
    .acc_s    (acc_s),
    .byte_val (narrow_byte),
    .sat      (narrow_sat_flag)
  );
`else
  // Signedness only matters when clamping.
  assign narrow_byte     = val[7:0];
  assign narrow_sat_flag = acc_s & 1'b0;
`endif

  assign first_word_byte  = (LITTLE_ENDIAN != 0) ? val[7:0]  : val[15:8];
  assign second_word_byte = (LITTLE_ENDIAN != 0) ? val[15:8] : val[7:0];
  assign in_ready         = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= 1'b0;
      second_q   <= 8'h00;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_last  <= 1'b0;
      sat        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state      <= S_B0;
            op_q       <= acc_op;
            second_q   <= second_word_byte;
            byte_valid <= 1'b1;
            byte_data  <= acc_op ? first_word_byte : narrow_byte;
            byte_last  <= ~acc_op;
            sat        <= acc_op ? 1'b0 : narrow_sat_flag;
          end
        end
        S_B0: begin
          if (byte_ready) begin
            if (op_q) begin
              state     <= S_B1;
              byte_data <= second_q;
              byte_last <= 1'b1;
              sat       <= 1'b0;
            end else begin
              state      <= S_IDLE;
              byte_valid <= 1'b0;
              byte_data  <= 8'h00;
              byte_last  <= 1'b0;
              sat        <= 1'b0;
            end
          end
        end
        S_B1: begin
          if (byte_ready) begin
            state      <= S_IDLE;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_last  <= 1'b0;
            sat        <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          byte_valid <= 1'b0;
          byte_data  <= 8'h00;
          byte_last  <= 1'b0;
          sat        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_narrow_store.sv
// Directed bench for narrow_store: narrow clamp cases, word ordering with stalls, reset abort, back-to-back.
module tb_narrow_store;

  localparam int LE = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] val;
  logic        acc_s;
  logic        acc_op;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        sat;

  int n_chk  = 0;
  int n_pass = 0;

  narrow_store #(.LITTLE_ENDIAN(LE)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .val        (val),
    .acc_s      (acc_s),
    .acc_op     (acc_op),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One narrow request with sink always ready.
  task automatic narrow(input string tag, input logic [15:0] v, input logic s,
                        input logic [7:0] exp_b, input logic exp_sat);
    in_valid = 1'b1; val = v; acc_s = s; acc_op = 1'b0; byte_ready = 1'b1;
    step();
    in_valid = 1'b0; val = 16'h0;
    chk({tag, "_valid"}, byte_valid, 1);
    chk({tag, "_data"},  byte_data, exp_b);
    chk({tag, "_sat"},   sat, exp_sat);
    chk({tag, "_last"},  byte_last, 1);
    chk({tag, "_busy"},  in_ready, 0);
    step();
    chk({tag, "_done_valid"}, byte_valid, 0);
    chk({tag, "_done_data"},  byte_data, 0);
    chk({tag, "_done_ready"}, in_ready, 1);
  endtask

  logic [7:0] w0, w1;
  int beats;

  initial begin
    rst = 1'b1; in_valid = 1'b0; val = 16'h0; acc_s = 1'b0; acc_op = 1'b0; byte_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", byte_valid, 0);
    chk("rst_data", byte_data, 0);
    chk("rst_last", byte_last, 0);
    chk("rst_sat", sat, 0);

`ifdef NARROW_STORE_SAT_EN
    narrow("s_008A", 16'h008A, 1'b1, 8'h7F, 1'b1);
    narrow("s_FF8A", 16'hFF8A, 1'b1, 8'h8A, 1'b0);
    narrow("s_FF00", 16'hFF00, 1'b1, 8'h80, 1'b1);
    narrow("u_008A", 16'h008A, 1'b0, 8'h8A, 1'b0);
    narrow("u_0100", 16'h0100, 1'b0, 8'hFF, 1'b1);
    narrow("u_00FF", 16'h00FF, 1'b0, 8'hFF, 1'b0);
`else
    narrow("s_008A", 16'h008A, 1'b1, 8'h8A, 1'b0);
    narrow("s_FF8A", 16'hFF8A, 1'b1, 8'h8A, 1'b0);
    narrow("s_FF00", 16'hFF00, 1'b1, 8'h00, 1'b0);
    narrow("u_008A", 16'h008A, 1'b0, 8'h8A, 1'b0);
    narrow("u_0100", 16'h0100, 1'b0, 8'h00, 1'b0);
    narrow("u_00FF", 16'h00FF, 1'b0, 8'hFF, 1'b0);
`endif

    // Word 1234 with 3 stall cycles on each beat; acc_s set to show it is ignored.
    w0 = (LE != 0) ? 8'h34 : 8'h12;
    w1 = (LE != 0) ? 8'h12 : 8'h34;
    in_valid = 1'b1; val = 16'h1234; acc_s = 1'b1; acc_op = 1'b1; byte_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("w_b0_valid", byte_valid, 1);
      chk("w_b0_data", byte_data, w0);
      chk("w_b0_last", byte_last, 0);
      chk("w_b0_sat", sat, 0);
      step();
    end
    byte_ready = 1'b1;
    step();
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("w_b1_valid", byte_valid, 1);
      chk("w_b1_data", byte_data, w1);
      chk("w_b1_last", byte_last, 1);
      chk("w_b1_ready", in_ready, 0);
      step();
    end
    byte_ready = 1'b1;
    step();
    chk("w_end_valid", byte_valid, 0);
    chk("w_end_ready", in_ready, 1);
    chk("w_end_data", byte_data, 0);

    // Reset while in S_B1 of word ABCD.
    in_valid = 1'b1; val = 16'hABCD; acc_s = 1'b0; acc_op = 1'b1; byte_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("r_b1_data", byte_data, (LE != 0) ? 8'hAB : 8'hCD);
    rst = 1'b1; byte_ready = 1'b0;
    step();
    rst = 1'b0;
    chk("r_valid", byte_valid, 0);
    chk("r_ready", in_ready, 1);
    chk("r_data", byte_data, 0);
    byte_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (byte_valid) beats++;
    end
    chk("r_no_beats", beats, 0);

    // in_valid held high across a word transfer.
    in_valid = 1'b1; val = 16'h1234; acc_op = 1'b1; byte_ready = 1'b1;
    step();
    val = 16'h5555;
    chk("bb_b0_data", byte_data, w0);
    chk("bb_b0_ready", in_ready, 0);
    step();
    chk("bb_b1_data", byte_data, w1);
    chk("bb_b1_last", byte_last, 1);
    chk("bb_b1_ready", in_ready, 0);
    step();
    chk("bb_gap_valid", byte_valid, 0);
    chk("bb_gap_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bb_2nd_valid", byte_valid, 1);
    chk("bb_2nd_data", byte_data, 8'h55);
    chk("bb_2nd_last", byte_last, 0);
    step();
    chk("bb_2nd_b1_last", byte_last, 1);
    step();
    chk("bb_2nd_end", byte_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
